// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// Decides each cycle whether PC, IF/ID and ID/EX advance, hold or get
// flushed/bubbled. It covers load-use stalls, taken-beq flushes and
// multi-cycle multiply occupancy.
// Optional feature macro: PIPE_HAZARD_FWD_EN.
//   Defined:   EX operand forwarding selects are generated, and only
//              load-use hazards stall.
//   Undefined: fwd_a/fwd_b are tied to 00, and every EX/MEM RAW hazard
//              stalls until the register file write-back.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_uses_rb,
  input  logic             id_is_mul,
  input  logic [4:0]       ex_dst,
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_dst,
  input  logic             mem_wen,
  input  logic             branch,
  input  logic             zero,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             mul_start,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = $clog2(MUL_CYCLES) + 1;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t          state, state_nxt;
  logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;

  logic taken;
  logic ex_ra, ex_rb, mem_ra, mem_rb;
  logic hz_ex, hz_mem, stall;

  // Register match detection; $0 never produces a hazard
  always_comb begin : hazard_detect
    taken  = branch & zero;
    ex_ra  = ex_wen & (ex_dst != '0) & (ex_dst == id_ra);
    ex_rb  = id_uses_rb & ex_wen & (ex_dst != '0) & (ex_dst == id_rb);
    mem_ra = mem_wen & (mem_dst != '0) & (mem_dst == id_ra);
    mem_rb = id_uses_rb & mem_wen & (mem_dst != '0) & (mem_dst == id_rb);
    hz_ex  = ex_ra | ex_rb;
    hz_mem = mem_ra | mem_rb;
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_q, fwd_b_q;

  // Only a load in EX cannot be forwarded in time
  always_comb begin : stall_gen
    stall   = id_valid & ex_is_load & hz_ex;
    fwd_a_d = ex_ra ? 2'b01 : (mem_ra ? 2'b10 : 2'b00);
    fwd_b_d = ex_rb ? 2'b01 : (mem_rb ? 2'b10 : 2'b00);
  end

  // Forwarding selects follow what ID/EX captures: load, clear on bubble, hold
  always_ff @(posedge clk) begin : fwd_reg
    if (!rst_n) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else if (idex_en) begin
      if (idex_bubble) begin
        fwd_a_q <= '0;
        fwd_b_q <= '0;
      end else begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  logic unused_load_flag;

  // Without forwarding any EX/MEM producer must reach write-back first
  always_comb begin : stall_gen
    stall = id_valid & (hz_ex | hz_mem);
  end

  assign unused_load_flag = ex_is_load;
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  // Next-state and pipeline enables; reset forces a held, flushed pipeline
  always_comb begin : fsm_comb
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    mul_start   = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_valid & id_is_mul) begin
            mul_start  = 1'b1;
            mc_cnt_nxt = MC_W'(MUL_CYCLES - 1);
            state_nxt  = MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          mc_cnt_nxt = mc_cnt - MC_W'(1);
          if (mc_cnt == MC_W'(1)) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State and multiply occupancy counter
  always_ff @(posedge clk) begin : fsm_reg
    if (!rst_n) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin : stall_counter
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign busy = (state == MUL_WAIT);

endmodule
